// File: rtl/proc_mem_if.sv
// Processor <-> 32x16 single-port memory bus. The memory read port is registered:
// p_MemRdata reflects the address presented on the previous clock edge.
interface proc_mem_if #(
  parameter int P_WORD = 16,
  parameter int P_ADDR = 5
);
  logic [P_ADDR-1:0] p_MemAddr;
  logic [P_WORD-1:0] p_MemData;
  logic              p_MemWrite;
  logic [P_WORD-1:0] p_MemRdata;

  modport master (output p_MemAddr, output p_MemData, output p_MemWrite, input p_MemRdata);
  modport slave  (input p_MemAddr, input p_MemData, input p_MemWrite, output p_MemRdata);
endinterface

// File: rtl/proc_mem_ctrl.sv
// Multicycle 16-bit processor: fetch/decode/execute FSM plus an 8-entry register
// file (R7 = PC) driving a single-port memory with a registered read port.
module proc_mem_ctrl #(
  parameter int P_WORD = 16,
  parameter int P_ADDR = 5,
  parameter int P_NREG = 8
) (
  input  logic              p_Clock,
  input  logic              p_Reset,
  input  logic              p_Run,
  proc_mem_if.master        mem,
  output logic              p_Done,
  output logic              p_Halted,
  output logic [P_ADDR-1:0] p_PC
);
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOADIR, S_EXEC, S_IMM, S_MEMRD, S_HALT
  } state_t;

  localparam logic [2:0] OP_MV   = 3'd0;
  localparam logic [2:0] OP_MVI  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_LD   = 3'd4;
  localparam logic [2:0] OP_ST   = 3'd5;
  localparam logic [2:0] OP_MVNZ = 3'd6;
  localparam int         PC_IDX  = P_NREG - 1;

  state_t            st_q, st_nxt;
  logic [P_WORD-1:0] rf_q   [P_NREG];
  logic [P_WORD-1:0] rf_nxt [P_NREG];
  logic              z_q, z_nxt;
  logic [8:0]        ir_q, ir_nxt;
  logic [P_WORD-1:0] alu;
  logic [2:0]        op, rx, ry, op_n, rx_n, ry_n;

  logic [P_ADDR-1:0] addr_q, addr_nxt;
  logic [P_WORD-1:0] data_q, data_nxt;
  logic              we_q, we_nxt, done_q, done_nxt, halt_q, halt_nxt;

  // PC advance touches only the address bits; R7's upper bits ride along untouched.
  function automatic logic [P_WORD-1:0] pc_inc(input logic [P_WORD-1:0] pc);
    logic [P_WORD-1:0] r;
    r = pc;
    r[P_ADDR-1:0] = pc[P_ADDR-1:0] + P_ADDR'(1);
    return r;
  endfunction

  assign op = ir_q[8:6];
  assign rx = ir_q[5:3];
  assign ry = ir_q[2:0];

  always_comb begin
    st_nxt = st_q;
    rf_nxt = rf_q;
    z_nxt  = z_q;
    ir_nxt = ir_q;
    alu    = '0;
    case (st_q)
      S_IDLE:   if (p_Run) st_nxt = S_FETCH;
      S_FETCH:  st_nxt = S_LOADIR;
      S_LOADIR: begin
        ir_nxt         = mem.p_MemRdata[P_WORD-1 -: 9];
        rf_nxt[PC_IDX] = pc_inc(rf_q[PC_IDX]);
        st_nxt         = S_EXEC;
      end
      S_EXEC: begin
        st_nxt = S_FETCH;
        case (op)
          OP_MV:   rf_nxt[rx] = rf_q[ry];
          OP_MVI:  st_nxt = S_IMM;
          OP_ADD: begin
            alu        = rf_q[rx] + rf_q[ry];
            rf_nxt[rx] = alu;
            z_nxt      = (alu == '0);
          end
          OP_SUB: begin
            alu        = rf_q[rx] - rf_q[ry];
            rf_nxt[rx] = alu;
            z_nxt      = (alu == '0);
          end
          OP_LD:   st_nxt = S_MEMRD;
          OP_ST:   ;
          OP_MVNZ: if (!z_q) rf_nxt[rx] = rf_q[ry];
          default: st_nxt = S_HALT;
        endcase
      end
      S_IMM: begin
        // Immediate load into R7 overrides the increment (ordering gives precedence).
        rf_nxt[PC_IDX] = pc_inc(rf_q[PC_IDX]);
        rf_nxt[rx]     = mem.p_MemRdata;
        st_nxt         = S_FETCH;
      end
      S_MEMRD: begin
        rf_nxt[rx] = mem.p_MemRdata;
        st_nxt     = S_FETCH;
      end
      default: st_nxt = S_HALT;
    endcase
  end

  assign op_n = ir_nxt[8:6];
  assign rx_n = ir_nxt[5:3];
  assign ry_n = ir_nxt[2:0];

  // Outputs are computed for the state being entered so they come straight off flops.
  always_comb begin
    addr_nxt = rf_nxt[PC_IDX][P_ADDR-1:0];
    data_nxt = '0;
    we_nxt   = 1'b0;
    done_nxt = 1'b0;
    halt_nxt = 1'b0;
    case (st_nxt)
      S_IDLE: addr_nxt = '0;
      S_EXEC: begin
        case (op_n)
          OP_MV, OP_ADD, OP_SUB, OP_MVNZ: done_nxt = 1'b1;
          OP_LD: addr_nxt = rf_nxt[ry_n][P_ADDR-1:0];
          OP_ST: begin
            addr_nxt = rf_nxt[ry_n][P_ADDR-1:0];
            data_nxt = rf_nxt[rx_n];
            we_nxt   = 1'b1;
            done_nxt = 1'b1;
          end
          default: ;
        endcase
      end
      S_IMM, S_MEMRD: done_nxt = 1'b1;
      S_HALT:         halt_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge p_Clock) begin
    if (p_Reset) begin
      st_q   <= S_IDLE;
      rf_q   <= '{default: '0};
      z_q    <= 1'b1;
      addr_q <= '0;
      data_q <= '0;
      we_q   <= 1'b0;
      done_q <= 1'b0;
      halt_q <= 1'b0;
    end else begin
      st_q   <= st_nxt;
      rf_q   <= rf_nxt;
      z_q    <= z_nxt;
      addr_q <= addr_nxt;
      data_q <= data_nxt;
      we_q   <= we_nxt;
      done_q <= done_nxt;
      halt_q <= halt_nxt;
    end
    ir_q <= ir_nxt;
  end

  // Reset must also kill a store already presented during the EXEC cycle.
  assign mem.p_MemAddr  = addr_q;
  assign mem.p_MemData  = data_q;
  assign mem.p_MemWrite = we_q & ~p_Reset;
  assign p_Done         = done_q;
  assign p_Halted       = halt_q;
  assign p_PC           = rf_q[PC_IDX][P_ADDR-1:0];
endmodule

// File: tb/tb_proc_mem_ctrl.sv
// Bench for proc_mem_ctrl: memory model plus an instruction-level reference
// interpreter; directed programs and random programs are compared against it.
module tb_proc_mem_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       load_en = 1'b0;
  logic       done, halted;
  logic [4:0] pc;

  proc_mem_if bus ();

  proc_mem_ctrl dut (
    .p_Clock (clk),
    .p_Reset (rst),
    .p_Run   (run),
    .mem     (bus),
    .p_Done  (done),
    .p_Halted(halted),
    .p_PC    (pc)
  );

  always #5 clk = ~clk;

  logic [15:0] mem  [32];
  logic [15:0] prog [32];

  always @(posedge clk) begin
    if (load_en) mem <= prog;
    else if (bus.p_MemWrite) mem[bus.p_MemAddr] <= bus.p_MemData;
    bus.p_MemRdata <= mem[bus.p_MemAddr];
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] ins(input int op, input int x, input int y);
    return 16'((op << 13) | (x << 10) | (y << 7));
  endfunction

  // Reference: sequential instruction interpreter with per-opcode cycle costs.
  logic [15:0] exp_rf  [8];
  logic [15:0] exp_mem [32];
  logic        exp_z;
  int          exp_cyc, exp_ret, exp_wr;
  bit          exp_halt;

  task automatic model_run(input int limit);
    logic [15:0] r [8];
    logic [15:0] m [32];
    logic [15:0] w, s;
    logic        zz;
    logic [2:0]  op;
    int          x, y;
    for (int i = 0; i < 8; i++) r[i] = '0;
    m = prog;
    zz = 1'b1;
    exp_cyc = 0; exp_ret = 0; exp_wr = 0; exp_halt = 0;
    while (!exp_halt && exp_ret < limit) begin
      w    = m[r[7][4:0]];
      r[7] = {r[7][15:5], r[7][4:0] + 5'd1};
      op   = w[15:13];
      x    = int'(w[12:10]);
      y    = int'(w[9:7]);
      case (op)
        3'd0: begin r[x] = r[y]; exp_cyc += 3; end
        3'd1: begin
          s    = m[r[7][4:0]];
          r[7] = {r[7][15:5], r[7][4:0] + 5'd1};
          r[x] = s;
          exp_cyc += 4;
        end
        3'd2: begin r[x] = r[x] + r[y]; zz = (r[x] == 16'd0); exp_cyc += 3; end
        3'd3: begin r[x] = r[x] - r[y]; zz = (r[x] == 16'd0); exp_cyc += 3; end
        3'd4: begin r[x] = m[r[y][4:0]]; exp_cyc += 4; end
        3'd5: begin m[r[y][4:0]] = r[x]; exp_wr++; exp_cyc += 3; end
        3'd6: begin if (!zz) r[x] = r[y]; exp_cyc += 3; end
        default: begin exp_halt = 1; exp_cyc += 3; end
      endcase
      if (op != 3'd7) exp_ret++;
    end
    exp_rf  = r;
    exp_mem = m;
    exp_z   = zz;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; run = 1'b0; load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  int          obs_cyc, obs_wr, obs_dn;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;

  // Runs until HALT or until `limit` instructions retire, then compares all state.
  task automatic run_program(input string name, input int limit);
    bit stop;
    model_run(limit);
    do_reset();
    run = 1'b1;
    obs_cyc = 0; obs_wr = 0; obs_dn = 0; stop = 0;
    wr_addr = '0; wr_data = '0;
    while (!stop && obs_cyc < 1000) begin
      @(negedge clk);
      obs_cyc++;
      run = 1'($urandom);
      if (halted) stop = 1;
      else begin
        if (bus.p_MemWrite) begin
          obs_wr++; wr_addr = bus.p_MemAddr; wr_data = bus.p_MemData;
        end
        if (done) begin
          obs_dn++;
          if (!exp_halt && obs_dn == exp_ret) begin
            @(negedge clk);
            stop = 1;
          end
        end
      end
    end
    run = 1'b0;
    check_eq({name, "_bounded"}, 32'(stop), 32'd1);
    check_eq({name, "_halted"}, 32'(halted), 32'(exp_halt));
    if (exp_halt) check_eq({name, "_cycles"}, obs_cyc, exp_cyc + 1);
    check_eq({name, "_retired"}, obs_dn, exp_ret);
    check_eq({name, "_writes"}, obs_wr, exp_wr);
    check_eq({name, "_pc"}, 32'(pc), 32'(exp_rf[7][4:0]));
    check_eq({name, "_z"}, 32'(dut.z_q), 32'(exp_z));
    for (int i = 0; i < 8; i++)
      check_eq($sformatf("%s_r%0d", name, i), 32'(dut.rf_q[i]), 32'(exp_rf[i]));
    for (int i = 0; i < 32; i++)
      check_eq($sformatf("%s_m%0d", name, i), 32'(mem[i]), 32'(exp_mem[i]));
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 32; i++) prog[i] = '0;
  endtask

  task automatic check_idle(input string name);
    check_eq({name, "_we"}, 32'(bus.p_MemWrite), 32'd0);
    check_eq({name, "_addr"}, 32'(bus.p_MemAddr), 32'd0);
    check_eq({name, "_data"}, 32'(bus.p_MemData), 32'd0);
    check_eq({name, "_done"}, 32'(done), 32'd0);
    check_eq({name, "_halted"}, 32'(halted), 32'd0);
    check_eq({name, "_pc"}, 32'(pc), 32'd0);
    for (int i = 0; i < 8; i++)
      check_eq($sformatf("%s_r%0d", name, i), 32'(dut.rf_q[i]), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_prog();
    do_reset();
    check_idle("rst");
    check_eq("rst_z", 32'(dut.z_q), 32'd1);

    // mvi R0,5 ; halt
    clear_prog();
    prog[0] = ins(1, 0, 0); prog[1] = 16'd5; prog[2] = ins(7, 0, 0);
    run_program("t1", 100);
    check_eq("t1_r0_const", 32'(dut.rf_q[0]), 32'd5);
    check_eq("t1_cycles_const", obs_cyc, 32'd8);
    check_eq("t1_done_const", obs_dn, 32'd1);
    run = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("t1_run_ignored", 32'(halted), 32'd1);
    run = 1'b0;

    // add with nonzero result
    clear_prog();
    prog[0] = ins(1, 0, 0); prog[1] = 16'd7;
    prog[2] = ins(1, 1, 0); prog[3] = 16'd9;
    prog[4] = ins(2, 0, 1); prog[5] = ins(7, 0, 0);
    run_program("t2a", 100);
    check_eq("t2a_r0_const", 32'(dut.rf_q[0]), 32'd16);
    check_eq("t2a_z_const", 32'(dut.z_q), 32'd0);

    // sub to zero, then wrap-around sub
    prog[4] = ins(3, 0, 0); prog[5] = ins(7, 0, 0);
    run_program("t2b", 100);
    check_eq("t2b_z_const", 32'(dut.z_q), 32'd1);
    prog[5] = ins(1, 2, 0); prog[6] = 16'd10; prog[7] = ins(3, 1, 2); prog[8] = ins(7, 0, 0);
    run_program("t2c", 100);
    check_eq("t2c_r1_const", 32'(dut.rf_q[1]), 32'hFFFF);

    // store then load through memory
    clear_prog();
    prog[0] = ins(1, 0, 0); prog[1] = 16'h1234;
    prog[2] = ins(1, 1, 0); prog[3] = 16'd20;
    prog[4] = ins(5, 0, 1); prog[5] = ins(4, 2, 1); prog[6] = ins(7, 0, 0);
    run_program("t3", 100);
    check_eq("t3_wr_count", obs_wr, 32'd1);
    check_eq("t3_wr_addr", 32'(wr_addr), 32'd20);
    check_eq("t3_wr_data", 32'(wr_data), 32'h1234);
    check_eq("t3_r2_const", 32'(dut.rf_q[2]), 32'h1234);

    // mvnz as a conditional jump
    clear_prog();
    prog[0] = ins(6, 7, 3); prog[1] = ins(1, 0, 0); prog[2] = 16'd1;
    prog[3] = ins(2, 0, 0); prog[4] = ins(6, 7, 3);
    run_program("t4a", 1);
    check_eq("t4a_pc_const", 32'(pc), 32'd1);
    run_program("t4b", 4);
    check_eq("t4b_pc_const", 32'(pc), 32'd0);

    // mvi at the top of memory wraps to address 0
    clear_prog();
    prog[0] = ins(1, 7, 0); prog[1] = 16'd31; prog[2] = ins(7, 0, 0);
    prog[31] = ins(1, 0, 0);
    run_program("t5", 2);
    check_eq("t5_r0_const", 32'(dut.rf_q[0]), 32'h3C00);
    check_eq("t5_pc_const", 32'(pc), 32'd1);

    // reset during the store EXEC cycle suppresses the write
    clear_prog();
    prog[0] = ins(5, 0, 1);
    do_reset();
    run = 1'b1;
    @(negedge clk); run = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("t6_we_before", 32'(bus.p_MemWrite), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("t6_we_gated", 32'(bus.p_MemWrite), 32'd0);
    @(negedge clk);
    check_eq("t6_mem0", 32'(mem[0]), 32'(ins(5, 0, 1)));
    check_idle("t6");
    rst = 1'b0;

    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < 32; i++) prog[i] = 16'($urandom);
      run_program($sformatf("rnd%0d", t), 30);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
